// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX pipeline register with stall, bubble insertion, debug freeze
// and a saturating bubble counter.
module id_ex_pipeline_register #(
    parameter int DATA_BUS_SIZE     = 32,
    parameter int REG_ADDR_BUS_SIZE = 5,
    parameter int OP_ALU_BUS_SIZE   = 2,
    parameter int BUBBLE_CNT_SIZE   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic                         i_valid,
    input  logic                         i_wb_reg_write,
    input  logic                         i_wb_mem_to_reg,
    input  logic                         i_mem_branch,
    input  logic                         i_mem_read,
    input  logic                         i_mem_write,
    input  logic                         i_ex_dest,
    input  logic                         i_ex_alu_src,
    input  logic [OP_ALU_BUS_SIZE-1:0]   i_ex_alu_op,
    input  logic [DATA_BUS_SIZE-1:0]     i_pc_next,
    input  logic [DATA_BUS_SIZE-1:0]     i_read_data_1,
    input  logic [DATA_BUS_SIZE-1:0]     i_read_data_2,
    input  logic [DATA_BUS_SIZE-1:0]     i_sign_ext_imm,
    input  logic [REG_ADDR_BUS_SIZE-1:0] i_rs,
    input  logic [REG_ADDR_BUS_SIZE-1:0] i_rt,
    input  logic [REG_ADDR_BUS_SIZE-1:0] i_rd,
    output logic                         o_wb_reg_write,
    output logic                         o_wb_mem_to_reg,
    output logic                         o_mem_branch,
    output logic                         o_mem_read,
    output logic                         o_mem_write,
    output logic                         o_ex_dest,
    output logic                         o_ex_alu_src,
    output logic [OP_ALU_BUS_SIZE-1:0]   o_ex_alu_op,
    output logic [DATA_BUS_SIZE-1:0]     o_pc_next,
    output logic [DATA_BUS_SIZE-1:0]     o_read_data_1,
    output logic [DATA_BUS_SIZE-1:0]     o_read_data_2,
    output logic [DATA_BUS_SIZE-1:0]     o_sign_ext_imm,
    output logic [REG_ADDR_BUS_SIZE-1:0] o_rs,
    output logic [REG_ADDR_BUS_SIZE-1:0] o_rt,
    output logic [REG_ADDR_BUS_SIZE-1:0] o_rd,
    output logic                         o_valid,
    output logic [BUBBLE_CNT_SIZE-1:0]   o_bubble_count
);

    // ctrl bit order: reg_write, mem_to_reg, branch, mem_read, mem_write, dest, alu_src
    logic [6:0]                   ctrl_q, ctrl_d;
    logic [OP_ALU_BUS_SIZE-1:0]   alu_op_q, alu_op_d;
    logic [DATA_BUS_SIZE-1:0]     pc_q, pc_d;
    logic [DATA_BUS_SIZE-1:0]     rd1_q, rd1_d;
    logic [DATA_BUS_SIZE-1:0]     rd2_q, rd2_d;
    logic [DATA_BUS_SIZE-1:0]     imm_q, imm_d;
    logic [REG_ADDR_BUS_SIZE-1:0] rs_q, rs_d;
    logic [REG_ADDR_BUS_SIZE-1:0] rt_q, rt_d;
    logic [REG_ADDR_BUS_SIZE-1:0] rd_q, rd_d;
    logic                         valid_q, valid_d;
    logic [BUBBLE_CNT_SIZE-1:0]   cnt_q, cnt_d;

    logic load_bubble;
    logic load_normal;

    // Flush outranks stall; an invalid ID slot only becomes a bubble when not stalled.
    assign load_bubble = i_enable & (i_flush | (~i_stall & ~i_valid));
    assign load_normal = i_enable & ~i_flush & ~i_stall & i_valid;

    always_comb begin
        ctrl_d   = ctrl_q;
        alu_op_d = alu_op_q;
        pc_d     = pc_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        if (load_bubble) begin
            ctrl_d   = '0;
            alu_op_d = '0;
            pc_d     = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            valid_d  = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + {{(BUBBLE_CNT_SIZE-1){1'b0}}, 1'b1};
            end
        end else if (load_normal) begin
            ctrl_d   = {i_wb_reg_write, i_wb_mem_to_reg, i_mem_branch, i_mem_read,
                        i_mem_write, i_ex_dest, i_ex_alu_src};
            alu_op_d = i_ex_alu_op;
            pc_d     = i_pc_next;
            rd1_d    = i_read_data_1;
            rd2_d    = i_read_data_2;
            imm_d    = i_sign_ext_imm;
            rs_d     = i_rs;
            rt_d     = i_rt;
            rd_d     = i_rd;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ctrl_q   <= '0;
            alu_op_q <= '0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign {o_wb_reg_write, o_wb_mem_to_reg, o_mem_branch, o_mem_read,
            o_mem_write, o_ex_dest, o_ex_alu_src} = ctrl_q;
    assign o_ex_alu_op    = alu_op_q;
    assign o_pc_next      = pc_q;
    assign o_read_data_1  = rd1_q;
    assign o_read_data_2  = rd2_q;
    assign o_sign_ext_imm = imm_q;
    assign o_rs           = rs_q;
    assign o_rt           = rt_q;
    assign o_rd           = rd_q;
    assign o_valid        = valid_q;
    assign o_bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb/tb_id_ex_pipeline_register.sv - scoreboard bench for id_ex_pipeline_register
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [1:0]  alu_op;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } fields_t;

    typedef struct packed {
        fields_t     f;
        logic        valid;
        logic [15:0] cnt;
    } slot_t;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    en, stall, flush, vld;
    fields_t in_s;
    slot_t   act;
    slot_t   model;
    slot_t   sb_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_register dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_stall(stall), .i_flush(flush), .i_valid(vld),
        .i_wb_reg_write(in_s.ctrl[6]), .i_wb_mem_to_reg(in_s.ctrl[5]), .i_mem_branch(in_s.ctrl[4]),
        .i_mem_read(in_s.ctrl[3]), .i_mem_write(in_s.ctrl[2]), .i_ex_dest(in_s.ctrl[1]),
        .i_ex_alu_src(in_s.ctrl[0]), .i_ex_alu_op(in_s.alu_op), .i_pc_next(in_s.pc),
        .i_read_data_1(in_s.rd1), .i_read_data_2(in_s.rd2), .i_sign_ext_imm(in_s.imm),
        .i_rs(in_s.rs), .i_rt(in_s.rt), .i_rd(in_s.rd),
        .o_wb_reg_write(act.f.ctrl[6]), .o_wb_mem_to_reg(act.f.ctrl[5]), .o_mem_branch(act.f.ctrl[4]),
        .o_mem_read(act.f.ctrl[3]), .o_mem_write(act.f.ctrl[2]), .o_ex_dest(act.f.ctrl[1]),
        .o_ex_alu_src(act.f.ctrl[0]), .o_ex_alu_op(act.f.alu_op), .o_pc_next(act.f.pc),
        .o_read_data_1(act.f.rd1), .o_read_data_2(act.f.rd2), .o_sign_ext_imm(act.f.imm),
        .o_rs(act.f.rs), .o_rt(act.f.rt), .o_rd(act.f.rd),
        .o_valid(act.valid), .o_bubble_count(act.cnt)
    );

    function automatic fields_t rand_fields();
        fields_t r;
        r.ctrl   = 7'($urandom);
        r.alu_op = 2'($urandom);
        r.pc     = $urandom;
        r.rd1    = $urandom;
        r.rd2    = $urandom;
        r.imm    = $urandom;
        r.rs     = 5'($urandom);
        r.rt     = 5'($urandom);
        r.rd     = 5'($urandom);
        return r;
    endfunction

    task automatic check(input string name, input slot_t got, input slot_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: an ID/EX slot is either frozen, a bubble, or a copy of ID; bubbles are counted up to 65535.
    task automatic step(input logic e, input logic s, input logic fl, input logic v, input fields_t f);
        @(negedge clk);
        en = e; stall = s; flush = fl; vld = v; in_s = f;
        if (e) begin
            if (fl || (!s && !v)) begin
                model.f     = '0;
                model.valid = 1'b0;
                model.cnt   = (model.cnt == 16'hFFFF) ? 16'hFFFF : model.cnt + 16'd1;
            end else if (!s) begin
                model.f     = f;
                model.valid = 1'b1;
            end
        end
        sb_q.push_back(model);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            check("edge_out", act, sb_q.pop_front());
        end
    end

    initial begin
        fields_t f;
        slot_t   held;
        rst_n = 1'b0; en = 1'b1; stall = 1'b0; flush = 1'b0; vld = 1'b1;
        in_s  = rand_fields();
        model = '0;
        repeat (2) @(posedge clk);
        #2 check("reset_zero", act, '0);
        @(negedge clk) rst_n = 1'b1;

        f = rand_fields(); f.rs = 5'd3; f.rd1 = 32'hDEAD_BEEF; f.ctrl[6] = 1'b1;
        step(1, 0, 0, 1, f);
        @(posedge clk) #2;
        n_tests++;
        if (act.f.rs !== 5'd3 || act.f.rd1 !== 32'hDEAD_BEEF || act.f.ctrl[6] !== 1'b1 || act.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_load: rs=%0d rd1=%h rw=%b v=%b expected 3 deadbeef 1 1",
                     act.f.rs, act.f.rd1, act.f.ctrl[6], act.valid);
        end

        f = rand_fields(); f.ctrl = 7'b1101001 & 7'b1101000; f.ctrl[3] = 1'b1; f.ctrl[0] = 1'b0; f.alu_op = 2'b00;
        step(1, 0, 0, 1, f);
        repeat (3) step(1, 1, 0, $urandom_range(0, 1), rand_fields());

        f = rand_fields(); f.ctrl[2] = 1'b1; f.rd = 5'd7;
        step(1, 1, 1, 1, f);

        repeat (4) step(0, $urandom_range(0, 1), 1, $urandom_range(0, 1), rand_fields());
        step(1, 0, 1, 1, rand_fields());

        f = rand_fields(); f.ctrl[1] = 1'bx;
        step(1, 0, 0, 0, f);
        f = rand_fields(); f.ctrl[6] = 1'b1; f.ctrl[1] = 1'b1; f.alu_op = 2'b10;
        step(1, 0, 0, 1, f);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, rand_fields());
        end

        for (int i = 0; i < 65537; i++) begin
            if ($urandom_range(0, 1) == 1) step(1, $urandom_range(0, 1), 1, $urandom_range(0, 1), rand_fields());
            else                           step(1, 0, 0, 0, rand_fields());
        end
        step(1, 1, 1, 0, rand_fields());
        step(1, 0, 0, 1, rand_fields());
        @(posedge clk) #2;
        n_tests++;
        if (act.cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturation: count=%h expected ffff", act.cnt);
        end

        step(1, 0, 0, 1, rand_fields());
        @(posedge clk) #3;
        held = act;
        rst_n = 1'b0;
        #1 check("async_reset", act, '0);
        n_tests++;
        if (held.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b expected 1", held.valid);
        end
        @(posedge clk) #2 check("reset_hold", act, '0);
        model = '0;
        @(negedge clk) rst_n = 1'b1;
        f = rand_fields();
        step(1, 0, 0, 1, f);
        step(1, 0, 0, 0, rand_fields());

        @(posedge clk) #3;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
